// File: rtl/ks_pkg.sv
// Shared helpers for the pipelined Kogge-Stone adder: level count, pipe-mask
// popcount and the widest mask the helpers accept.
package ks_pkg;

    localparam int KS_MAX_LEVELS = 8;

    typedef logic [KS_MAX_LEVELS:0] ks_mask_t;

    function automatic int ks_levels(input int width);
        return (width <= 2) ? 1 : $clog2(width);
    endfunction

    // Number of register banks, i.e. the latency in cycles.
    function automatic int ks_popcount(input ks_mask_t mask);
        int n;
        n = 0;
        for (int i = 0; i <= KS_MAX_LEVELS; i++) begin
            n += int'(mask[i]);
        end
        return n;
    endfunction

endpackage

// File: rtl/ks_adder_pipe_prefix_level.sv
// One combinational row of Kogge-Stone carry operators with a fixed span;
// bits below the span pass straight through.
module ks_prefix_level #(
    parameter int WIDTH = 16,
    parameter int SPAN  = 1
) (
    input  logic [WIDTH-1:0] g_in,
    input  logic [WIDTH-1:0] p_in,
    output logic [WIDTH-1:0] g_out,
    output logic [WIDTH-1:0] p_out
);

    always_comb begin
        g_out = g_in;
        p_out = p_in;
        for (int i = SPAN; i < WIDTH; i++) begin
            g_out[i] = g_in[i] | (p_in[i] & g_in[i-SPAN]);
            p_out[i] = p_in[i] & p_in[i-SPAN];
        end
    end

endmodule

// File: rtl/ks_adder_pipe.sv
// Parametrised Kogge-Stone adder/subtractor with an optional register bank
// after each prefix level and valid/ready flow control.
module ks_adder_pipe
    import ks_pkg::*;
#(
    parameter int                    WIDTH     = 16,
    parameter logic [ks_levels(WIDTH):0] PIPE_MASK = 5'b00101
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    input  logic             in_cin,
    input  logic             in_sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_sum,
    output logic             out_cout,
    output logic             out_ovf
);

    localparam int L = ks_levels(WIDTH);

    // Handshake: a beat moves across a boundary when valid & ready are both
    // high at the clock edge; ready never depends on the valid it qualifies.
    logic [WIDTH-1:0] b_eff;
    logic [WIDTH:0]   carry;

    assign b_eff = in_b ^ {WIDTH{in_sub}};

    for (genvar i = 0; i <= L; i++) begin : lvl
        logic [WIDTH-1:0] cg, cp, cp0;
        logic [WIDTH-1:0] sg, sp, sp0;
        logic             cc0, cv, sc0, sv;
        logic             up_rdy, dn_rdy;

        if (i == 0) begin : gp
            assign cg  = in_a & b_eff;
            assign cp  = in_a ^ b_eff;
            assign cp0 = in_a ^ b_eff;
            assign cc0 = in_cin ^ in_sub;
            assign cv  = in_valid;
        end else begin : pfx
            ks_prefix_level #(
                .WIDTH (WIDTH),
                .SPAN  (1 << (i - 1))
            ) u_row (
                .g_in  (lvl[i-1].sg),
                .p_in  (lvl[i-1].sp),
                .g_out (cg),
                .p_out (cp)
            );
            assign cp0 = lvl[i-1].sp0;
            assign cc0 = lvl[i-1].sc0;
            assign cv  = lvl[i-1].sv;
        end

        if (i == L) begin : tail
            assign dn_rdy = out_ready;
        end else begin : mid
            assign dn_rdy = lvl[i+1].up_rdy;
        end

        if (PIPE_MASK[i]) begin : bank
            logic             v_q, c0_q;
            logic [WIDTH-1:0] g_q, p_q, p0_q;

            // Bank loads when empty or when its beat leaves this same cycle.
            assign up_rdy = !v_q || dn_rdy;

            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    v_q  <= 1'b0;
                    c0_q <= 1'b0;
                    g_q  <= '0;
                    p_q  <= '0;
                    p0_q <= '0;
                end else if (up_rdy) begin
                    v_q <= cv;
                    if (cv) begin
                        c0_q <= cc0;
                        g_q  <= cg;
                        p_q  <= cp;
                        p0_q <= cp0;
                    end
                end
            end

            assign sv  = v_q;
            assign sc0 = c0_q;
            assign sg  = g_q;
            assign sp  = p_q;
            assign sp0 = p0_q;
        end else begin : thru
            assign up_rdy = dn_rdy;
            assign sv     = cv;
            assign sc0    = cc0;
            assign sg     = cg;
            assign sp     = cp;
            assign sp0    = cp0;
        end
    end

    // After the last level G/P span the full prefix, so every carry is a
    // single step from c0.
    always_comb begin
        carry[0] = lvl[L].sc0;
        for (int i = 1; i <= WIDTH; i++) begin
            carry[i] = lvl[L].sg[i-1] | (lvl[L].sp[i-1] & lvl[L].sc0);
        end
    end

    assign out_sum   = lvl[L].sp0 ^ carry[WIDTH-1:0];
    assign out_cout  = carry[WIDTH];
    assign out_ovf   = carry[WIDTH] ^ carry[WIDTH-1];
    assign out_valid = lvl[L].sv;
    assign in_ready  = lvl[0].up_rdy;

endmodule
